// File: rtl/vend_multi.sv
// Token vending controller: N products, per-product price, saturating credit, cancel/timeout refund, optional change return.
// Latency: every output is registered and reflects an input one clk after it is sampled; reset clears the outputs asynchronously.
// Backpressure: coffee_select/coffee_select_done are held until dispense_done; tokens offered while the credit cannot take them get token_reject.
module vend_multi #(
    parameter int N_PRODUCTS  = 3,
    parameter int CREDIT_W    = 8,
    parameter logic [N_PRODUCTS*CREDIT_W-1:0] PRICES = {8'd3, 8'd2, 8'd1},
    parameter int MAX_CREDIT  = 15,
    parameter int TIMEOUT_CYC = 1000,
    parameter int CHANGE_MODE = 1,
    localparam int SEL_W      = $clog2(N_PRODUCTS + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  token_in,
    input  logic [N_PRODUCTS-1:0] button,
    input  logic                  cancel,
    input  logic                  dispense_done,
    output logic                  coffee_select_done,
    output logic [SEL_W-1:0]      coffee_select,
    output logic                  token_reject,
    output logic                  refund_valid,
    output logic [CREDIT_W-1:0]   refund_tokens,
    output logic [CREDIT_W-1:0]   credit
);

    // The idle counter only has to count up to TIMEOUT_CYC-1, where it fires.
    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [CREDIT_W-1:0] CRED_MAX = CREDIT_W'(MAX_CREDIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_DISPENSE,
        ST_REFUND
    } state_t;

    state_t              state, state_nx;
    logic [TMO_W-1:0]    tmo_cnt, tmo_nx;
    logic [CREDIT_W-1:0] credit_nx;
    logic [SEL_W-1:0]    sel_nx;
    logic                done_nx;
    logic                rej_nx;
    logic                rv_nx;
    logic [CREDIT_W-1:0] rt_nx;

    logic                btn_hit;
    logic [SEL_W-1:0]    btn_sel;
    logic [CREDIT_W-1:0] sel_price;
    logic [CREDIT_W-1:0] remainder;

    // Pick the lowest affordable pressed button; look up the price of the product being dispensed.
    always_comb begin
        btn_hit   = 1'b0;
        btn_sel   = '0;
        sel_price = '0;
        for (int i = N_PRODUCTS - 1; i >= 0; i--) begin
            if (button[i] && (PRICES[i*CREDIT_W +: CREDIT_W] <= credit)) begin
                btn_hit = 1'b1;
                btn_sel = SEL_W'(i + 1);
            end
            if (coffee_select == SEL_W'(i + 1)) begin
                sel_price = PRICES[i*CREDIT_W +: CREDIT_W];
            end
        end
        // The selection was affordable when made, but never let credit wrap.
        remainder = (sel_price <= credit) ? credit - sel_price : '0;
    end

    // Next-state and next-output logic; pulses default low, held outputs default to their current value.
    always_comb begin
        state_nx  = state;
        tmo_nx    = tmo_cnt;
        credit_nx = credit;
        sel_nx    = coffee_select;
        done_nx   = coffee_select_done;
        rej_nx    = 1'b0;
        rv_nx     = 1'b0;
        rt_nx     = '0;
        case (state)
            ST_IDLE: begin
                credit_nx = '0;
                if (token_in) begin
                    credit_nx = CREDIT_W'(1);
                    tmo_nx    = '0;
                    state_nx  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (cancel) begin
                    tmo_nx   = '0;
                    rv_nx    = 1'b1;
                    rt_nx    = credit;
                    state_nx = ST_REFUND;
                end else if (token_in) begin
                    tmo_nx = '0;
                    if (credit >= CRED_MAX) begin
                        rej_nx = 1'b1;
                    end else begin
                        credit_nx = credit + CREDIT_W'(1);
                    end
                end else if (|button) begin
                    tmo_nx = '0;
                    if (btn_hit) begin
                        sel_nx   = btn_sel;
                        done_nx  = 1'b1;
                        state_nx = ST_DISPENSE;
                    end
                end else if (TIMEOUT_CYC != 0) begin
                    if (tmo_cnt == TMO_LAST) begin
                        tmo_nx   = '0;
                        rv_nx    = 1'b1;
                        rt_nx    = credit;
                        state_nx = ST_REFUND;
                    end else begin
                        tmo_nx = tmo_cnt + TMO_W'(1);
                    end
                end
            end
            ST_DISPENSE: begin
                rej_nx = token_in;
                if (dispense_done) begin
                    sel_nx    = '0;
                    done_nx   = 1'b0;
                    credit_nx = remainder;
                    tmo_nx    = '0;
                    if (remainder == '0) begin
                        state_nx = ST_IDLE;
                    end else if (CHANGE_MODE != 0) begin
                        rv_nx    = 1'b1;
                        rt_nx    = remainder;
                        state_nx = ST_REFUND;
                    end else begin
                        state_nx = ST_CREDIT;
                    end
                end
            end
            ST_REFUND: begin
                rej_nx    = token_in;
                credit_nx = '0;
                state_nx  = ST_IDLE;
            end
            default: begin
                credit_nx = '0;
                sel_nx    = '0;
                done_nx   = 1'b0;
                state_nx  = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops everything immediately, including a selection in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= ST_IDLE;
            tmo_cnt            <= '0;
            credit             <= '0;
            coffee_select      <= '0;
            coffee_select_done <= 1'b0;
            token_reject       <= 1'b0;
            refund_valid       <= 1'b0;
            refund_tokens      <= '0;
        end else begin
            state              <= state_nx;
            tmo_cnt            <= tmo_nx;
            credit             <= credit_nx;
            coffee_select      <= sel_nx;
            coffee_select_done <= done_nx;
            token_reject       <= rej_nx;
            refund_valid       <= rv_nx;
            refund_tokens      <= rt_nx;
        end
    end

endmodule

// File: tb/tb_vend_multi.sv
module tb_vend_multi;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       token_in = 1'b0;
    logic [2:0] button = 3'b000;
    logic       cancel = 1'b0;
    logic       dispense_done = 1'b0;
    logic       coffee_select_done;
    logic [1:0] coffee_select;
    logic       token_reject;
    logic       refund_valid;
    logic [7:0] refund_tokens;
    logic [7:0] credit;

    int n_checks = 0;
    int n_pass   = 0;

    vend_multi dut (
        .clk                (clk),
        .reset              (reset),
        .token_in           (token_in),
        .button             (button),
        .cancel             (cancel),
        .dispense_done      (dispense_done),
        .coffee_select_done (coffee_select_done),
        .coffee_select      (coffee_select),
        .token_reject       (token_reject),
        .refund_valid       (refund_valid),
        .refund_tokens      (refund_tokens),
        .credit             (credit)
    );

    always #5 clk = ~clk;

    // One clock; outputs are sampled 1ns after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tokens(input int n);
        token_in = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        token_in = 1'b0;
    endtask

    task automatic press(input logic [2:0] b);
        button = b;
        cyc();
        button = 3'b000;
    endtask

    task automatic finish_dispense();
        dispense_done = 1'b1;
        cyc();
        dispense_done = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        cyc();
        n_checks++;
        if ({coffee_select_done, coffee_select, token_reject, refund_valid, refund_tokens, credit} !== 22'd0)
            $display("FAIL reset_outputs: got sel=%0d done=%0b rej=%0b rv=%0b rt=%0d credit=%0d, want all 0",
                     coffee_select, coffee_select_done, token_reject, refund_valid, refund_tokens, credit);
        else n_pass++;
        reset = 1'b1;
        cyc();
        n_checks++;
        if (credit !== 8'd0) $display("FAIL idle_credit: got %0d want 0", credit); else n_pass++;
    endtask

    task automatic test_basic();
        tokens(3);
        n_checks++;
        if (credit !== 8'd3) $display("FAIL basic_credit: got %0d want 3", credit); else n_pass++;
        press(3'b100);
        n_checks++;
        if (coffee_select !== 2'd3 || coffee_select_done !== 1'b1)
            $display("FAIL basic_select: got sel=%0d done=%0b want sel=3 done=1", coffee_select, coffee_select_done);
        else n_pass++;
        cyc(); cyc();
        n_checks++;
        if (coffee_select !== 2'd3 || coffee_select_done !== 1'b1)
            $display("FAIL basic_hold: got sel=%0d done=%0b want sel=3 done=1", coffee_select, coffee_select_done);
        else n_pass++;
        tokens(1);
        n_checks++;
        if (token_reject !== 1'b1 || credit !== 8'd3)
            $display("FAIL dispense_token: got rej=%0b credit=%0d want rej=1 credit=3", token_reject, credit);
        else n_pass++;
        finish_dispense();
        n_checks++;
        if (coffee_select !== 2'd0 || coffee_select_done !== 1'b0 || credit !== 8'd0 || refund_valid !== 1'b0)
            $display("FAIL basic_done: got sel=%0d done=%0b credit=%0d rv=%0b want 0 0 0 0",
                     coffee_select, coffee_select_done, credit, refund_valid);
        else n_pass++;
    endtask

    task automatic test_unaffordable();
        tokens(1);
        press(3'b010);
        n_checks++;
        if (coffee_select !== 2'd0 || coffee_select_done !== 1'b0 || credit !== 8'd1)
            $display("FAIL unaffordable: got sel=%0d done=%0b credit=%0d want 0 0 1", coffee_select, coffee_select_done, credit);
        else n_pass++;
        tokens(1);
        press(3'b010);
        n_checks++;
        if (coffee_select !== 2'd2 || coffee_select_done !== 1'b1)
            $display("FAIL affordable: got sel=%0d done=%0b want sel=2 done=1", coffee_select, coffee_select_done);
        else n_pass++;
        finish_dispense();
        n_checks++;
        if (credit !== 8'd0 || refund_valid !== 1'b0)
            $display("FAIL exact_change: got credit=%0d rv=%0b want 0 0", credit, refund_valid);
        else n_pass++;
    endtask

    task automatic test_change();
        tokens(5);
        press(3'b001);
        n_checks++;
        if (coffee_select !== 2'd1) $display("FAIL change_select: got %0d want 1", coffee_select); else n_pass++;
        finish_dispense();
        n_checks++;
        if (refund_valid !== 1'b1 || refund_tokens !== 8'd4 || coffee_select_done !== 1'b0)
            $display("FAIL change_refund: got rv=%0b rt=%0d done=%0b want rv=1 rt=4 done=0",
                     refund_valid, refund_tokens, coffee_select_done);
        else n_pass++;
        cyc();
        n_checks++;
        if (refund_valid !== 1'b0 || refund_tokens !== 8'd0 || credit !== 8'd0)
            $display("FAIL change_after: got rv=%0b rt=%0d credit=%0d want 0 0 0", refund_valid, refund_tokens, credit);
        else n_pass++;
    endtask

    task automatic test_priority();
        tokens(2);
        press(3'b111);
        n_checks++;
        if (coffee_select !== 2'd1) $display("FAIL lowest_index: got sel=%0d want 1", coffee_select); else n_pass++;
        finish_dispense();
        n_checks++;
        if (refund_valid !== 1'b1 || refund_tokens !== 8'd1)
            $display("FAIL priority_refund: got rv=%0b rt=%0d want rv=1 rt=1", refund_valid, refund_tokens);
        else n_pass++;
        cyc();
    endtask

    task automatic test_saturate();
        int rejects;
        rejects = 0;
        token_in = 1'b1;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (token_reject) rejects++;
        end
        n_checks++;
        if (rejects !== 0 || credit !== 8'd15)
            $display("FAIL sat_fill: got rejects=%0d credit=%0d want 0 15", rejects, credit);
        else n_pass++;
        cyc();
        token_in = 1'b0;
        n_checks++;
        if (token_reject !== 1'b1 || credit !== 8'd15)
            $display("FAIL sat_16th: got rej=%0b credit=%0d want rej=1 credit=15", token_reject, credit);
        else n_pass++;
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        n_checks++;
        if (token_reject !== 1'b0 || refund_valid !== 1'b1 || refund_tokens !== 8'd15)
            $display("FAIL sat_cancel: got rej=%0b rv=%0b rt=%0d want 0 1 15", token_reject, refund_valid, refund_tokens);
        else n_pass++;
        cyc();
        n_checks++;
        if (credit !== 8'd0 || refund_valid !== 1'b0)
            $display("FAIL sat_idle: got credit=%0d rv=%0b want 0 0", credit, refund_valid);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int first;
        first = 0;
        tokens(2);
        for (int k = 1; k <= 1010; k++) begin
            cyc();
            if (refund_valid && first == 0) begin
                first = k;
                n_checks++;
                if (refund_tokens !== 8'd2) $display("FAIL timeout_tokens: got %0d want 2", refund_tokens);
                else n_pass++;
            end
        end
        n_checks++;
        if (first !== 1000) $display("FAIL timeout_cycle: refund after %0d idle cycles, want 1000", first);
        else n_pass++;
        n_checks++;
        if (credit !== 8'd0) $display("FAIL timeout_idle: got credit=%0d want 0", credit); else n_pass++;
    endtask

    task automatic test_cancel();
        tokens(2);
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        n_checks++;
        if (refund_valid !== 1'b1 || refund_tokens !== 8'd2)
            $display("FAIL cancel_refund: got rv=%0b rt=%0d want 1 2", refund_valid, refund_tokens);
        else n_pass++;
        token_in = 1'b1;
        cyc();
        token_in = 1'b0;
        n_checks++;
        if (token_reject !== 1'b1 || credit !== 8'd0 || refund_valid !== 1'b0)
            $display("FAIL refund_token: got rej=%0b credit=%0d rv=%0b want 1 0 0", token_reject, credit, refund_valid);
        else n_pass++;
    endtask

    task automatic test_token_button();
        tokens(2);
        token_in = 1'b1;
        button   = 3'b010;
        cyc();
        token_in = 1'b0;
        button   = 3'b000;
        n_checks++;
        if (credit !== 8'd3 || coffee_select !== 2'd0 || coffee_select_done !== 1'b0)
            $display("FAIL token_button: got credit=%0d sel=%0d done=%0b want 3 0 0", credit, coffee_select, coffee_select_done);
        else n_pass++;
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
        n_checks++;
        if (refund_tokens !== 8'd3) $display("FAIL token_button_refund: got %0d want 3", refund_tokens); else n_pass++;
        cyc();
    endtask

    task automatic test_reset_dispense();
        tokens(1);
        press(3'b001);
        n_checks++;
        if (coffee_select_done !== 1'b1) $display("FAIL rst_setup: got done=%0b want 1", coffee_select_done); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({coffee_select_done, coffee_select, token_reject, refund_valid, refund_tokens, credit} !== 22'd0)
            $display("FAIL rst_mid_dispense: got sel=%0d done=%0b credit=%0d rv=%0b want all 0",
                     coffee_select, coffee_select_done, credit, refund_valid);
        else n_pass++;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unaffordable();
        test_change();
        test_priority();
        test_saturate();
        test_timeout();
        test_cancel();
        test_token_button();
        test_reset_dispense();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
